gcm_ctr_sequencer: RTL and testbench
====================================

Name: gcm_ctr_sequencer

Overview:
Front-end framing and counter sequencer for the AES-GCM datapath. It accepts plaintext blocks framed by i_new/i_last and produces the matching counter block IV||inc32(ctr) for each one. At the end of each message it produces the GHASH length block len(A)||len(C). It also carries the sideband (bypass) word through a parametrised delay line so the sideband stays aligned with the cipher pipeline latency.

Parameters:
DATA_W, 128, block width in bits; fixed at 128 in this generation, exposed for lint only
IV_W, 96, IV width; counter width is DATA_W-IV_W (32)
BYPASS_W, 289, sideband width
BYPASS_LAT, 4, sideband delay in cycles from accept to o_bypass_text; 1..64

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
i_new  in  1  one block presented this cycle
i_last  in  1  qualifies i_new; block is the final one of the message
i_iv  in  IV_W  IV; sampled only on the first block of a message
i_aad_bits  in  64  AAD length in bits; sampled with i_iv
i_valid_bytes  in  5  valid bytes in the block, 1..16; 0 is treated as 16
i_plain_text  in  DATA_W  block data; byte 0 in bits [127:120]
i_bypass_text  in  BYPASS_W  sideband word
o_valid  out  1  o_ctr_block/o_plain_text valid
o_last  out  1  o_valid block is the final one of the message
o_ctr_block  out  DATA_W  IV||ctr
o_plain_text  out  DATA_W  block data with invalid trailing bytes zeroed
o_j0  out  DATA_W  IV||32'h1, held for the whole message (tag mask input)
o_len_valid  out  1  one-cycle pulse; o_len_block valid
o_len_block  out  DATA_W  {len(A)[63:0], len(C)[63:0]} in bits
o_bypass_text  out  BYPASS_W  i_bypass_text delayed BYPASS_LAT cycles
o_drop  out  1  one-cycle pulse; a presented block was rejected
o_busy  out  1  high in RUN or LEN

Behaviour:
- Reset:
  - All outputs are 0; state = IDLE; ctr = 0; byte count = 0.
  - The delay line is cleared to 0.
  - Reset mid-message discards the message; no o_len_valid is produced for it.
- States:
  - IDLE: i_new latches i_iv and i_aad_bits; the block uses ctr = 2, then ctr becomes 3. If i_last=0 go to RUN; if i_last=1 go to LEN.
  - RUN: each i_new uses the current ctr, then ctr increments. When i_last=1, go to LEN.
  - LEN: lasts one cycle. o_len_valid=1 and o_len_block = {aad_bits, byte_cnt*8}. Then go to IDLE and clear byte_cnt and ctr.
  - An i_new presented while in LEN is not accepted: o_drop pulses the next cycle and no o_valid is produced.
  - o_busy=1 in RUN and LEN.
- Counter:
  - ctr is 32 bits and wraps modulo 2^32 (FFFFFFFF -> 00000000). The IV part never changes.
  - o_j0 = {IV, 32'h00000001}; it updates when the first block is accepted.
- Byte count:
  - byte_cnt is 61 bits and accumulates i_valid_bytes (0 counts as 16) for every accepted block.
  - i_valid_bytes<16 on a non-last block is accepted unchanged, with no error.
- Latency:
  - o_valid/o_last/o_ctr_block/o_plain_text are registered outputs, exactly 1 cycle after the accepted i_new.
  - Between blocks, o_valid=0 and the data outputs hold their last value.
- Masking: bytes with index >= valid_bytes are forced to 0 in o_plain_text.
- Bypass delay line:
  - It shifts every cycle, independent of i_new, for a fixed latency of BYPASS_LAT.
  - It is not gated by o_drop.
- Back-to-back: i_new may be asserted every cycle. The only stall is the single LEN cycle after a last block.
- o_len_valid timing: asserted in the cycle after the last block's o_valid, i.e. 2 cycles after the last i_new.

Test Plan:
1. Reset, then three messages of one block each:
   - Stimulus: i_iv=CAFEBABEFACEDBADDECAF888, i_aad_bits=0, i_last=1 on each.
   - Response per message: o_ctr_block=CAFEBABEFACEDBADDECAF88800000002; o_j0=...00000001; o_len_block=0000000000000000_0000000000000080.
2. Four-block message (i_new on alternate cycles, i_last on the 4th), i_aad_bits=0xA0:
   - o_ctr_block counters are 2,3,4,5; o_last=1 only on the 4th.
   - o_len_valid pulses 2 cycles after the last i_new, with o_len_block={00000000000000A0, 0000000000000200}.
3. Partial last block, i_valid_bytes=12, i_plain_text=D9313225F88406E5A55909C5AFF5269A:
   - o_plain_text=D9313225F88406E5A55909C500000000.
   - len(C) = 16*8*(n-1)+96.
4. Counter wrap (internal ctr forced to FFFFFFFF):
   - Next o_ctr_block ends in 00000000, then 00000001.
   - The IV field is unchanged.
5. i_new with i_last asserted in consecutive cycles:
   - The second block lands in LEN, so o_drop=1 and no o_valid is produced for it.
   - An i_new in the following cycle starts a new message with ctr=2.
6. BYPASS_LAT=4, i_bypass_text incremented every cycle; reset asserted mid-message:
   - o_bypass_text equals the input from exactly 4 cycles earlier.
   - After reset, all outputs are 0, o_bypass_text is 0 for 4 cycles, and no o_len_valid appears for the aborted message.

Source files
------------

// File: rtl/gcm_ctr_sequencer.sv
// gcm_ctr_sequencer: framing and counter sequencer for the AES-GCM front end.
// Every accepted plaintext block leaves one cycle later with its counter block
// IV||ctr and its trailing invalid bytes zeroed. The cycle after a message's
// last block emits the GHASH length block len(A)||len(C). The sideband word
// travels through a fixed-latency delay line so it stays aligned with the
// downstream cipher pipeline.
module gcm_ctr_sequencer #(
  parameter int DATA_W     = 128,
  parameter int IV_W       = 96,
  parameter int BYPASS_W   = 289,
  parameter int BYPASS_LAT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_new,
  input  logic                i_last,
  input  logic [IV_W-1:0]     i_iv,
  input  logic [63:0]         i_aad_bits,
  input  logic [4:0]          i_valid_bytes,
  input  logic [DATA_W-1:0]   i_plain_text,
  input  logic [BYPASS_W-1:0] i_bypass_text,
  output logic                o_valid,
  output logic                o_last,
  output logic [DATA_W-1:0]   o_ctr_block,
  output logic [DATA_W-1:0]   o_plain_text,
  output logic [DATA_W-1:0]   o_j0,
  output logic                o_len_valid,
  output logic [DATA_W-1:0]   o_len_block,
  output logic [BYPASS_W-1:0] o_bypass_text,
  output logic                o_drop,
  output logic                o_busy
);

  localparam int CTR_W = DATA_W - IV_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LEN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IV_W-1:0]     iv_q, iv_d;
  logic [63:0]         aad_q, aad_d;
  logic [CTR_W-1:0]    ctr_q, ctr_d;
  logic [60:0]         byte_cnt_q, byte_cnt_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   ctr_block_q, ctr_block_d;
  logic [DATA_W-1:0]   plain_q, plain_d;
  logic [DATA_W-1:0]   j0_q, j0_d;
  logic                len_valid_q, len_valid_d;
  logic [DATA_W-1:0]   len_block_q, len_block_d;
  logic                drop_q, drop_d;
  logic                busy_q, busy_d;
  logic [BYPASS_W-1:0] byp_q [BYPASS_LAT];
  logic [BYPASS_W-1:0] byp_d [BYPASS_LAT];

  // Scratch values for the block being accepted this cycle.
  logic                accept;
  logic [IV_W-1:0]     blk_iv;
  logic [CTR_W-1:0]    blk_ctr;
  logic [4:0]          eff_bytes;
  logic [DATA_W-1:0]   masked_text;

  // Byte masking: a zero byte count means a full block.
  always_comb begin
    eff_bytes   = (i_valid_bytes == 5'd0) ? 5'd16 : i_valid_bytes;
    masked_text = '0;
    for (int b = 0; b < NB; b++) begin
      if (5'(b) < eff_bytes) begin
        masked_text[DATA_W-1-8*b -: 8] = i_plain_text[DATA_W-1-8*b -: 8];
      end
    end
  end

  // Next-state and next-output logic for the message sequencer.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned;
    // a missing default would make synthesis infer a latch.
    state_d     = state_q;
    iv_d        = iv_q;
    aad_d       = aad_q;
    ctr_d       = ctr_q;
    byte_cnt_d  = byte_cnt_q;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    ctr_block_d = ctr_block_q;
    plain_d     = plain_q;
    j0_d        = j0_q;
    len_valid_d = 1'b0;
    len_block_d = len_block_q;
    drop_d      = 1'b0;
    accept      = 1'b0;
    blk_iv      = iv_q;
    blk_ctr     = ctr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_new) begin
          // First block of a message: capture IV/AAD and start at ctr = 2,
          // since ctr = 1 is reserved for J0 (the tag mask).
          accept     = 1'b1;
          iv_d       = i_iv;
          aad_d      = i_aad_bits;
          j0_d       = {i_iv, CTR_W'(1)};
          blk_iv     = i_iv;
          blk_ctr    = CTR_W'(2);
          ctr_d      = CTR_W'(3);
          byte_cnt_d = 61'(eff_bytes);
          state_d    = i_last ? ST_LEN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_new) begin
          accept     = 1'b1;
          blk_ctr    = ctr_q;
          ctr_d      = ctr_q + CTR_W'(1);
          byte_cnt_d = byte_cnt_q + 61'(eff_bytes);
          if (i_last) state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        // Single stall cycle: emit the length block; any block offered now is
        // rejected and flagged.
        len_valid_d = 1'b1;
        len_block_d = {aad_q, byte_cnt_q, 3'b000};
        ctr_d       = '0;
        byte_cnt_d  = '0;
        drop_d      = i_new;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      valid_d     = 1'b1;
      last_d      = i_last;
      ctr_block_d = {blk_iv, blk_ctr};
      plain_d     = masked_text;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= ST_IDLE;
      iv_q        <= '0;
      aad_q       <= '0;
      ctr_q       <= '0;
      byte_cnt_q  <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      ctr_block_q <= '0;
      plain_q     <= '0;
      j0_q        <= '0;
      len_valid_q <= 1'b0;
      len_block_q <= '0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      iv_q        <= iv_d;
      aad_q       <= aad_d;
      ctr_q       <= ctr_d;
      byte_cnt_q  <= byte_cnt_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      ctr_block_q <= ctr_block_d;
      plain_q     <= plain_d;
      j0_q        <= j0_d;
      len_valid_q <= len_valid_d;
      len_block_q <= len_block_d;
      drop_q      <= drop_d;
      busy_q      <= busy_d;
    end
  end

  // Sideband delay line: shifts every cycle, independent of framing.
  always_comb begin
    byp_d[0] = i_bypass_text;
    for (int i = 1; i < BYPASS_LAT; i++) begin
      byp_d[i] = byp_q[i-1];
    end
  end

  // Sideband delay line registers.
  always_ff @(posedge clk) begin
    // NOTE: this small storage array is reset on purpose so stale sideband
    // words never leak out after a reset; large RAM-like arrays would not be.
    if (reset) begin
      for (int i = 0; i < BYPASS_LAT; i++) byp_q[i] <= '0;
    end else begin
      for (int i = 0; i < BYPASS_LAT; i++) byp_q[i] <= byp_d[i];
    end
  end

  assign o_valid       = valid_q;
  assign o_last        = last_q;
  assign o_ctr_block   = ctr_block_q;
  assign o_plain_text  = plain_q;
  assign o_j0          = j0_q;
  assign o_len_valid   = len_valid_q;
  assign o_len_block   = len_block_q;
  assign o_drop        = drop_q;
  assign o_busy        = busy_q;
  assign o_bypass_text = byp_q[BYPASS_LAT-1];

endmodule

// File: tb/tb_gcm_ctr_sequencer.sv
// Scoreboard bench for gcm_ctr_sequencer: the driver runs a message-level
// reference model and queues expected outputs with their due cycle; a monitor
// on the falling edge pops and compares whenever the DUT presents something.
module tb_gcm_ctr_sequencer;

  localparam int DATA_W     = 128;
  localparam int IV_W       = 96;
  localparam int BYPASS_W   = 289;
  localparam int BYPASS_LAT = 4;

  logic                clk;
  logic                reset;
  logic                i_new;
  logic                i_last;
  logic [IV_W-1:0]     i_iv;
  logic [63:0]         i_aad_bits;
  logic [4:0]          i_valid_bytes;
  logic [DATA_W-1:0]   i_plain_text;
  logic [BYPASS_W-1:0] i_bypass_text;
  logic                o_valid;
  logic                o_last;
  logic [DATA_W-1:0]   o_ctr_block;
  logic [DATA_W-1:0]   o_plain_text;
  logic [DATA_W-1:0]   o_j0;
  logic                o_len_valid;
  logic [DATA_W-1:0]   o_len_block;
  logic [BYPASS_W-1:0] o_bypass_text;
  logic                o_drop;
  logic                o_busy;

  gcm_ctr_sequencer #(
    .DATA_W(DATA_W), .IV_W(IV_W), .BYPASS_W(BYPASS_W), .BYPASS_LAT(BYPASS_LAT)
  ) dut (
    .clk(clk), .reset(reset), .i_new(i_new), .i_last(i_last), .i_iv(i_iv),
    .i_aad_bits(i_aad_bits), .i_valid_bytes(i_valid_bytes),
    .i_plain_text(i_plain_text), .i_bypass_text(i_bypass_text),
    .o_valid(o_valid), .o_last(o_last), .o_ctr_block(o_ctr_block),
    .o_plain_text(o_plain_text), .o_j0(o_j0), .o_len_valid(o_len_valid),
    .o_len_block(o_len_block), .o_bypass_text(o_bypass_text),
    .o_drop(o_drop), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] ctr_block;
    logic [127:0] plain;
    logic [127:0] j0;
    logic         last;
    int           due;
  } blk_t;

  blk_t  exp_blk_q[$];
  int    exp_len_due_q[$];
  logic [127:0] exp_len_q[$];
  int    exp_drop_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [BYPASS_W-1:0] hist[$];
  bit                  hist_ok = 1'b0;
  logic [31:0]         byp_cnt = '0;

  // Message-level reference model state.
  bit           m_in_msg = 1'b0;
  bit           m_len    = 1'b0;
  logic [95:0]  m_iv     = '0;
  logic [63:0]  m_aad    = '0;
  logic [31:0]  m_ctr    = '0;
  logic [63:0]  m_bytes  = '0;

  task automatic check(input string name, input logic [288:0] got, input logic [288:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock of stimulus plus the model's view of what it should cause.
  task automatic cycle(input bit rst, input bit nw, input bit lst, input logic [4:0] vb,
                       input logic [127:0] pt, input logic [95:0] iv, input logic [63:0] aad);
    int           eff;
    bit           cur_len;
    logic [127:0] mask;
    logic [255:0] r;
    check("busy", 289'(o_busy), 289'(m_in_msg || m_len));
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    reset         = rst;
    i_new         = nw;
    i_last        = lst;
    i_valid_bytes = vb;
    i_plain_text  = pt;
    i_iv          = iv;
    i_aad_bits    = aad;
    i_bypass_text = {1'b1, r, byp_cnt};
    byp_cnt++;
    cur_len = m_len;
    m_len   = 1'b0;
    if (rst) begin
      if (cur_len) void'(exp_len_q.pop_back());
      if (cur_len) void'(exp_len_due_q.pop_back());
      m_in_msg = 1'b0;
    end else if (nw) begin
      if (cur_len) begin
        exp_drop_q.push_back(cyc + 1);
      end else begin
        if (!m_in_msg) begin
          m_iv = iv; m_aad = aad; m_ctr = 32'd2; m_bytes = '0;
        end
        eff  = (vb == 5'd0) ? 16 : int'(vb);
        mask = '1;
        mask = mask << (8 * (16 - eff));
        exp_blk_q.push_back('{ctr_block: {m_iv, m_ctr}, plain: pt & mask,
                              j0: {m_iv, 32'h1}, last: lst, due: cyc + 1});
        m_ctr   = m_ctr + 32'd1;
        m_bytes = m_bytes + 64'(eff);
        if (lst) begin
          exp_len_q.push_back({m_aad, m_bytes * 64'd8});
          exp_len_due_q.push_back(cyc + 2);
          m_in_msg = 1'b0;
          m_len    = 1'b1;
        end else begin
          m_in_msg = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0);
  endtask

  task automatic blk(input bit lst, input logic [4:0] vb, input logic [127:0] pt,
                     input logic [95:0] iv, input logic [63:0] aad);
    cycle(1'b0, 1'b1, lst, vb, pt, iv, aad);
  endtask

  task automatic check_zero();
    check("rst_valid",     289'(o_valid),      '0);
    check("rst_last",      289'(o_last),       '0);
    check("rst_ctr_block", 289'(o_ctr_block),  '0);
    check("rst_plain",     289'(o_plain_text), '0);
    check("rst_j0",        289'(o_j0),         '0);
    check("rst_len_valid", 289'(o_len_valid),  '0);
    check("rst_len_block", 289'(o_len_block),  '0);
    check("rst_drop",      289'(o_drop),       '0);
    check("rst_bypass",    o_bypass_text,      '0);
  endtask

  // Cycle counter and sideband input history, sampled on the active edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        hist.delete();
        for (int k = 0; k < BYPASS_LAT; k++) hist.push_back('0);
        hist_ok = 1'b1;
      end else if (hist_ok) begin
        hist.push_back(i_bypass_text);
        if (hist.size() > 2 * BYPASS_LAT) void'(hist.pop_front());
      end
    end
  end

  // Monitor: compare whatever the DUT presents against the queued expectations.
  initial begin
    blk_t e;
    forever begin
      @(negedge clk);
      if (hist_ok) check("bypass", o_bypass_text, hist[hist.size() - BYPASS_LAT]);
      if (o_valid) begin
        if (exp_blk_q.size() == 0) begin
          check("unexpected_valid", 289'(o_valid), '0);
        end else begin
          e = exp_blk_q.pop_front();
          check("blk_time",  289'(cyc),          289'(e.due));
          check("ctr_block", 289'(o_ctr_block),  289'(e.ctr_block));
          check("plain",     289'(o_plain_text), 289'(e.plain));
          check("j0",        289'(o_j0),         289'(e.j0));
          check("last",      289'(o_last),       289'(e.last));
        end
      end
      if (o_len_valid) begin
        if (exp_len_q.size() == 0) begin
          check("unexpected_len", 289'(o_len_valid), '0);
        end else begin
          check("len_time",  289'(cyc),         289'(exp_len_due_q.pop_front()));
          check("len_block", 289'(o_len_block), 289'(exp_len_q.pop_front()));
        end
      end
      if (o_drop) begin
        if (exp_drop_q.size() == 0) check("unexpected_drop", 289'(o_drop), '0);
        else check("drop_time", 289'(cyc), 289'(exp_drop_q.pop_front()));
      end
    end
  end

  // Stimulus.
  initial begin
    logic [95:0] iv;
    int          nblk;
    reset = 1'b1; i_new = 1'b0; i_last = 1'b0; i_iv = '0; i_aad_bits = '0;
    i_valid_bytes = '0; i_plain_text = '0; i_bypass_text = '0;
    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b0, 5'd0, '0, '0, '0);
    cycle(1'b1, 1'b0, 1'b0, 5'd0, '0, '0, '0);
    check_zero();

    // Three one-block messages.
    for (int m = 0; m < 3; m++) begin
      blk(1'b1, 5'd16, rnd128(), 96'hCAFEBABEFACEDBADDECAF888, 64'd0);
      idle(2);
    end

    // Four-block message on alternate cycles.
    iv = rnd128()[95:0];
    for (int b = 0; b < 4; b++) begin
      blk(b == 3, 5'd0, rnd128(), iv, 64'hA0);
      if (b != 3) idle(1);
    end
    idle(2);

    // Partial last block.
    iv = rnd128()[95:0];
    blk(1'b0, 5'd16, rnd128(), iv, 64'd40);
    blk(1'b0, 5'd16, rnd128(), iv, 64'd40);
    blk(1'b1, 5'd12, 128'hD9313225F88406E5A55909C5AFF5269A, iv, 64'd40);
    idle(2);

    // Counter wrap.
    iv = rnd128()[95:0];
    blk(1'b0, 5'd16, rnd128(), iv, 64'd0);
    force dut.ctr_q = 32'hFFFF_FFFF;
    idle(1);
    release dut.ctr_q;
    m_ctr = 32'hFFFF_FFFF;
    blk(1'b0, 5'd16, rnd128(), iv, 64'd0);
    blk(1'b0, 5'd16, rnd128(), iv, 64'd0);
    blk(1'b1, 5'd16, rnd128(), iv, 64'd0);
    idle(2);

    // Back-to-back last blocks: the second lands in LEN and is dropped.
    blk(1'b1, 5'd16, rnd128(), rnd128()[95:0], 64'd8);
    blk(1'b1, 5'd16, rnd128(), rnd128()[95:0], 64'd8);
    blk(1'b1, 5'd5,  rnd128(), rnd128()[95:0], 64'd16);
    idle(2);

    // Reset mid-message.
    iv = rnd128()[95:0];
    for (int b = 0; b < 3; b++) blk(1'b0, 5'd16, rnd128(), iv, 64'd24);
    cycle(1'b1, 1'b0, 1'b0, 5'd0, '0, '0, '0);
    cycle(1'b1, 1'b0, 1'b0, 5'd0, '0, '0, '0);
    check_zero();
    idle(5);
    blk(1'b1, 5'd16, rnd128(), iv, 64'd0);
    idle(2);

    // Randomized messages with random gaps; a zero gap after a last block
    // deliberately collides with the LEN cycle.
    for (int m = 0; m < 30; m++) begin
      iv   = rnd128()[95:0];
      nblk = $urandom_range(1, 5);
      for (int b = 0; b < nblk; b++) begin
        blk(b == nblk - 1, 5'($urandom_range(0, 16)), rnd128(), iv, {$urandom, $urandom});
        if (b != nblk - 1) idle($urandom_range(0, 1));
      end
      idle($urandom_range(0, 2));
    end

    idle(6);
    check("blk_q_empty",  289'(exp_blk_q.size()),  '0);
    check("len_q_empty",  289'(exp_len_q.size()),  '0);
    check("drop_q_empty", 289'(exp_drop_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Time bound in case the run ever stalls.
  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
